// File: rtl/wb_pipe_stage.sv
// EX->WB elastic pipeline stage: valid/ready handshake with a two-entry skid buffer,
// flush, and a saturating count of downstream stall cycles.
module wb_pipe_stage #(
  parameter int DATA_W = 32,
  parameter int SEL_W  = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_we,
  input  logic [SEL_W-1:0]  in_sel,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_we,
  output logic [SEL_W-1:0]  out_sel,
  output logic [CNT_W-1:0]  stall_cnt
);

  localparam int ENT_W = DATA_W + SEL_W + 1;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL  = 2'd1,
    SKID  = 2'd2
  } state_t;

  state_t             state_r, state_s;
  logic [ENT_W-1:0]   main_r, main_s;
  logic [ENT_W-1:0]   skid_r, skid_s;
  logic [ENT_W-1:0]   in_ent_s;
  logic               in_ready_r, out_valid_r, out_we_r;
  logic [CNT_W-1:0]   stall_r;
  logic               in_fire_s, out_fire_s;

  // Entry layout: {we, sel, data}
  assign in_ent_s   = {in_we, in_sel, in_data};
  assign in_fire_s  = in_valid & in_ready_r;
  assign out_fire_s = out_valid_r & out_ready;

  // Next-state and next-entry selection; flush wins over any accept
  always_comb begin
    state_s = state_r;
    main_s  = main_r;
    skid_s  = skid_r;
    if (flush) begin
      state_s = EMPTY;
      main_s  = {ENT_W{1'b0}};
      skid_s  = {ENT_W{1'b0}};
    end else begin
      case (state_r)
        EMPTY: begin
          if (in_fire_s) begin
            state_s = FULL;
            main_s  = in_ent_s;
          end else begin
            state_s = EMPTY;
          end
        end
        FULL: begin
          if (in_fire_s && out_ready) begin
            state_s = FULL;
            main_s  = in_ent_s;
          end else if (in_fire_s) begin
            state_s = SKID;
            skid_s  = in_ent_s;
          end else if (out_fire_s) begin
            state_s = EMPTY;
          end else begin
            state_s = FULL;
          end
        end
        SKID: begin
          if (out_fire_s) begin
            state_s = FULL;
            main_s  = skid_r;
          end else begin
            state_s = SKID;
          end
        end
        default: begin
          state_s = EMPTY;
          main_s  = {ENT_W{1'b0}};
          skid_s  = {ENT_W{1'b0}};
        end
      endcase
    end
  end

  // State, entry storage, handshake flags and stall counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= EMPTY;
      main_r      <= {ENT_W{1'b0}};
      skid_r      <= {ENT_W{1'b0}};
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      out_we_r    <= 1'b0;
      stall_r     <= {CNT_W{1'b0}};
    end else begin
      state_r     <= state_s;
      main_r      <= main_s;
      skid_r      <= skid_s;
      in_ready_r  <= (state_s != SKID);
      out_valid_r <= (state_s != EMPTY);
      out_we_r    <= main_s[ENT_W-1] & (state_s != EMPTY);
      if (out_valid_r && !out_ready && (stall_r != {CNT_W{1'b1}})) begin
        stall_r <= stall_r + CNT_W'(1);
      end else begin
        stall_r <= stall_r;
      end
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign out_we    = out_we_r;
  assign out_data  = main_r[DATA_W-1:0];
  assign out_sel   = main_r[DATA_W +: SEL_W];
  assign stall_cnt = stall_r;

endmodule
